// File: rtl/fconv_sched.sv
// fconv_sched: shares one int16->float32 converter among N_CH channels, round-robin issue.
// Latency: strobe captured at edge E, issued at E+1, result registered at E+1+CONV_LAT.
// Backpressure: none; a held sample overwritten before issue raises a sticky overrun bit.
module fconv_sched #(
    parameter int N_CH     = 6,
    parameter int CONV_LAT = 6,
    parameter int CH_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      smp_strobe,
    input  logic [16*N_CH-1:0]   smp_data,
    output logic [15:0]          conv_dataa,
    input  logic [31:0]          conv_result,
    output logic [32*N_CH-1:0]   f_data,
    output logic [N_CH-1:0]      f_valid,
    output logic [N_CH-1:0]      overrun,
    input  logic                 clr_overrun,
    output logic                 busy
);

    logic [15:0]         hold [N_CH];
    logic [N_CH-1:0]     pending;
    logic [CH_W-1:0]     rr_ptr;
    logic [CONV_LAT-1:0] tag_vld;
    logic [CH_W-1:0]     tag_ch [CONV_LAT];

    logic [2*N_CH-1:0]   pend2;
    logic [N_CH-1:0]     rot;
    logic [CH_W:0]       gsum;
    logic                gnt_vld;
    logic [CH_W-1:0]     gnt_ch;
    logic [N_CH-1:0]     issue;

    // Round-robin grant: rotate pending so rr_ptr sits at bit 0, take the lowest set bit,
    // then map the offset back to an absolute channel number modulo N_CH.
    always_comb begin
        pend2   = {pending, pending};
        rot     = N_CH'(pend2 >> rr_ptr);
        gnt_vld = 1'b0;
        gsum    = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                gnt_vld = 1'b1;
                gsum    = (CH_W+1)'(rr_ptr) + (CH_W+1)'(i);
            end
        end
        if (gsum >= (CH_W+1)'(N_CH)) begin
            gnt_ch = CH_W'(gsum - (CH_W+1)'(N_CH));
        end else begin
            gnt_ch = CH_W'(gsum);
        end
        issue = gnt_vld ? (N_CH'(1) << gnt_ch) : '0;
    end

    // Capture, issue, overrun tracking and the channel-tag pipe that shadows the converter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                hold[c] <= '0;
            end
            for (int s = 0; s < CONV_LAT; s++) begin
                tag_ch[s] <= '0;
            end
            pending    <= '0;
            overrun    <= '0;
            rr_ptr     <= '0;
            tag_vld    <= '0;
            conv_dataa <= '0;
            f_data     <= '0;
            f_valid    <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (smp_strobe[c]) begin
                    hold[c] <= smp_data[16*c +: 16];
                end
            end
            // A strobe on the channel being issued re-arms pending: the old value goes out now,
            // the new one waits its turn.
            pending <= (pending & ~issue) | smp_strobe;
            // Set has priority over the clear so a simultaneous overrun is never lost.
            overrun <= (overrun & ~{N_CH{clr_overrun}}) | (smp_strobe & pending & ~issue);

            if (gnt_vld) begin
                conv_dataa <= hold[gnt_ch];
                rr_ptr     <= (gnt_ch == CH_W'(N_CH - 1)) ? '0 : gnt_ch + CH_W'(1);
            end

            for (int s = CONV_LAT - 1; s > 0; s--) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_ch[s]  <= tag_ch[s-1];
            end
            tag_vld[0] <= gnt_vld;
            tag_ch[0]  <= gnt_ch;

            f_valid <= '0;
            for (int c = 0; c < N_CH; c++) begin
                if (tag_vld[CONV_LAT-1] && tag_ch[CONV_LAT-1] == CH_W'(c)) begin
                    f_data[32*c +: 32] <= conv_result;
                    f_valid[c]         <= 1'b1;
                end
            end
        end
    end

    // A conversion counts as in flight until its f_valid cycle has been presented.
    assign busy = (|pending) | (|tag_vld) | (|f_valid);

endmodule

// File: tb/tb_fconv_sched.sv
// tb_fconv_sched: directed vectors and corner sequences for the shared converter scheduler.
// Converter modelled as a dataa delay line feeding a combinational int16->float32 function.
// Outputs sampled 1 time unit after each rising edge; inputs also driven there.
module tb_fconv_sched;

    localparam int N_CH     = 6;
    localparam int CONV_LAT = 6;
    localparam int CH_W     = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_CH-1:0]      smp_strobe;
    logic [16*N_CH-1:0]   smp_data;
    logic [15:0]          conv_dataa;
    logic [31:0]          conv_result;
    logic [32*N_CH-1:0]   f_data;
    logic [N_CH-1:0]      f_valid;
    logic [N_CH-1:0]      overrun;
    logic                 clr_overrun;
    logic                 busy;

    int total = 0;
    int bad   = 0;

    fconv_sched #(.N_CH(N_CH), .CONV_LAT(CONV_LAT), .CH_W(CH_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .smp_strobe  (smp_strobe),
        .smp_data    (smp_data),
        .conv_dataa  (conv_dataa),
        .conv_result (conv_result),
        .f_data      (f_data),
        .f_valid     (f_valid),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Exact int16 -> float32 (every int16 fits in 24 bits of mantissa, so no rounding).
    function automatic logic [31:0] i2f(input logic [15:0] v);
        logic        s;
        logic [16:0] a;
        logic [39:0] t;
        int          m;
        if (v == 16'h0000) return 32'h0;
        s = v[15];
        a = s ? (17'd0 - {v[15], v}) : {1'b0, v};
        m = 0;
        for (int i = 0; i < 17; i++) if (a[i]) m = i;
        t = {23'b0, a} << (23 - m);
        return {s, 8'(127 + m), t[22:0]};
    endfunction

    // Result is ready for the edge CONV_LAT clocks after the dataa update.
    logic [15:0] cpipe [0:CONV_LAT-2];
    always @(posedge clk) begin
        cpipe[0] <= conv_dataa;
        for (int i = 1; i < CONV_LAT - 1; i++) cpipe[i] <= cpipe[i-1];
    end
    assign conv_result = i2f(cpipe[CONV_LAT-2]);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst         = 1'b1;
        smp_strobe  = '0;
        clr_overrun = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Single uncontended sample: checks issue value, f_valid latency, mask, data and busy fall.
    task automatic run_single(input int ch, input logic [15:0] smp, input logic [31:0] fexp);
        int hit;
        smp_data[16*ch +: 16] = smp;
        smp_strobe            = N_CH'(1) << ch;
        tick();
        smp_strobe = '0;
        chk("busy_after_capture", busy, 1);
        tick();
        chk("dataa_issue", conv_dataa, smp);
        hit = 0;
        for (int k = 3; k <= CONV_LAT + 6 && hit == 0; k++) begin
            tick();
            if (f_valid != '0) hit = k;
        end
        chk("fvalid_latency", hit, CONV_LAT + 2);
        chk("fvalid_mask", f_valid, N_CH'(1) << ch);
        chk("fdata_value", f_data[32*ch +: 32], fexp);
        chk("busy_at_fvalid", busy, 1);
        tick();
        chk("fvalid_one_cycle", f_valid, 0);
        chk("busy_fall", busy, 0);
    endtask

    typedef struct {
        int          ch;
        logic [15:0] smp;
        logic [31:0] fexp;
    } vec_t;

    vec_t        tbl [7];
    logic [31:0] walk_exp [6];

    initial begin
        int hit;
        int pulses;

        tbl[0] = '{2, 16'hFF9C, 32'hC2C80000};
        tbl[1] = '{0, 16'h0001, 32'h3F800000};
        tbl[2] = '{5, 16'hFFFF, 32'hBF800000};
        tbl[3] = '{3, 16'h7FFF, 32'h46FFFE00};
        tbl[4] = '{1, 16'h8000, 32'hC7000000};
        tbl[5] = '{4, 16'h0000, 32'h00000000};
        tbl[6] = '{2, 16'h0064, 32'h42C80000};
        walk_exp[0] = 32'h3F800000; walk_exp[1] = 32'h40000000;
        walk_exp[2] = 32'h40400000; walk_exp[3] = 32'h40800000;
        walk_exp[4] = 32'h40A00000; walk_exp[5] = 32'h40C00000;

        smp_data = '0;
        do_reset();
        chk("rst_fdata", f_data == '0, 1);
        chk("rst_fvalid", f_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_dataa", conv_dataa, 0);
        chk("rst_busy", busy, 0);

        // Single-channel vectors; the first one is ch2 = -100.
        for (int v = 0; v < 7; v++) run_single(tbl[v].ch, tbl[v].smp, tbl[v].fexp);

        // All six strobe together with 1..6: issue order ch0..ch5, f_valid walks.
        do_reset();
        for (int c = 0; c < N_CH; c++) smp_data[16*c +: 16] = 16'(c + 1);
        smp_strobe = '1;
        tick();
        smp_strobe = '0;
        for (int i = 0; i < N_CH; i++) begin
            tick();
            chk("walk_dataa", conv_dataa, 16'(i + 1));
        end
        hit = 0;
        for (int k = 8; k <= CONV_LAT + 8 && hit == 0; k++) begin
            tick();
            if (f_valid != '0) hit = k;
        end
        chk("walk_latency", hit, CONV_LAT + 2);
        for (int i = 0; i < N_CH; i++) begin
            if (i > 0) tick();
            chk("walk_fvalid", f_valid, N_CH'(1) << i);
            chk("walk_fdata", f_data[32*i +: 32], walk_exp[i]);
        end

        // ch0 streaming, ch3 strobes once: ch3 must win the next slot.
        do_reset();
        smp_data[15:0] = 16'h0100; smp_strobe = 6'b000001;
        tick();
        smp_data[15:0] = 16'h0101; smp_strobe = 6'b000001;
        tick();
        chk("stream_dataa0", conv_dataa, 16'h0100);
        chk("stream_no_ovr_a", overrun, 0);
        smp_data[15:0] = 16'h0102; smp_data[63:48] = 16'h3333; smp_strobe = 6'b001001;
        tick();
        chk("stream_dataa1", conv_dataa, 16'h0101);
        chk("stream_no_ovr_b", overrun, 0);
        smp_data[15:0] = 16'h0103; smp_strobe = 6'b000001;
        tick();
        smp_strobe = '0;
        chk("stream_ch3_issued", conv_dataa, 16'h3333);

        // Overrun on ch4, newer value wins, clear, then set-beats-clear on ch5.
        do_reset();
        for (int c = 0; c < N_CH; c++) smp_data[16*c +: 16] = 16'(200 + c);
        smp_strobe = '1;
        tick();
        smp_strobe = '0;
        tick();
        smp_data[79:64] = 16'hABCD; smp_strobe = 6'b010000;
        tick();
        smp_strobe = '0;
        chk("ovr_ch4", overrun, 6'b010000);
        for (int k = 0; k < 20; k++) tick();
        chk("ovr_newest_ch4", f_data[159:128], i2f(16'hABCD));
        chk("ovr_ch1_kept", f_data[63:32], i2f(16'd201));
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("ovr_clear", overrun, 0);
        smp_data[15:0] = 16'h0011; smp_data[95:80] = 16'h0055; smp_strobe = 6'b100001;
        tick();
        smp_data[95:80] = 16'h0066; smp_strobe = 6'b100000; clr_overrun = 1'b1;
        tick();
        smp_strobe = '0; clr_overrun = 1'b0;
        chk("ovr_set_beats_clr", overrun, 6'b100000);

        // Reset with 3 conversions in flight and 2 pending.
        do_reset();
        for (int c = 0; c < N_CH; c++) smp_data[16*c +: 16] = 16'(16'h0301 + c);
        smp_strobe = 6'b011111;
        tick();
        smp_strobe = '0;
        tick(); tick(); tick();
        do_reset();
        chk("mid_rst_fdata", f_data == '0, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_dataa", conv_dataa, 0);
        pulses = 0;
        for (int k = 0; k < CONV_LAT + 4; k++) begin
            tick();
            if (f_valid != '0) pulses++;
        end
        chk("mid_rst_no_fvalid", pulses, 0);
        smp_data[31:16] = 16'h0111; smp_data[95:80] = 16'h0555; smp_strobe = 6'b100010;
        tick();
        smp_strobe = '0;
        tick();
        chk("mid_rst_rrptr0", conv_dataa, 16'h0111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
